// File: rtl/bsg_wormhole_router_input_sequencer_pkg.sv
// Shared wormhole definitions: header field placement and the input
// sequencer state encoding.
package bsg_wormhole_router_input_sequencer_pkg;

  // The direction field sits in the low bits of the header flit.
  localparam int hdr_dir_lsb_lp = 0;

  // Two-state sequencer: expecting a header, or forwarding body flits.
  localparam logic [0:0] state_header_lp = 1'b0;
  localparam logic [0:0] state_body_lp   = 1'b1;

  // The length field starts immediately above the direction field.
  function automatic int hdr_len_lsb(input int dir_width);
    return hdr_dir_lsb_lp + dir_width;
  endfunction

endpackage

// File: rtl/bsg_wormhole_router_flit_counter.sv
// Body-flit counter: loaded with the header length, decremented once per
// consumed body flit. last_o flags the final body flit of the packet.
module bsg_wormhole_router_flit_counter
  #(parameter int width_p = 4)
  (input  logic               clk_i,
   input  logic               reset_i,
   input  logic               load_i,
   input  logic [width_p-1:0] count_i,
   input  logic               dec_i,
   output logic               last_o);

  logic [width_p-1:0] count_r;

  // Load has priority; decrement only happens while forwarding body flits,
  // where the count is always at least one, so it never wraps.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r <= {width_p{1'b0}};
    end else if (load_i) begin
      count_r <= count_i;
    end else if (dec_i) begin
      count_r <= count_r - width_p'(32'd1);
    end else begin
      count_r <= count_r;
    end
  end

  assign last_o = (count_r == width_p'(32'd1));

endmodule

// File: rtl/bsg_wormhole_router_input_sequencer.sv
// Wormhole router input sequencer: decodes the header at the input FIFO
// head, requests the routed output, steers body flits to it and releases
// the output with a one-cycle pulse after the packet's last flit.
module bsg_wormhole_router_input_sequencer
  import bsg_wormhole_router_input_sequencer_pkg::*;
  #(parameter int dirs_p       = 2,
    parameter int flit_width_p = 16,
    parameter int len_width_p  = 4,
    parameter int dir_width_p  = (dirs_p > 1) ? $clog2(dirs_p) : 1)
  (input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    fifo_v_i,
   input  logic [flit_width_p-1:0] fifo_data_i,
   input  logic                    yumi_i,
   output logic [dirs_p-1:0]       reqs_o,
   output logic [dirs_p-1:0]       valid_o,
   output logic [dirs_p-1:0]       release_o,
   output logic                    fifo_yumi_o,
   output logic                    error_o);

  localparam int len_lsb_lp = hdr_len_lsb(dir_width_p);
  localparam int hdr_top_lp = len_lsb_lp + len_width_p;

  logic [0:0]             state_r;
  logic [0:0]             state_next_s;
  logic [dir_width_p-1:0] hdr_dir_s;
  logic [dir_width_p-1:0] dir_r;
  logic [len_width_p-1:0] hdr_len_s;
  logic [dirs_p-1:0]      hdr_onehot_s;
  logic [dirs_p-1:0]      body_onehot_s;
  logic [dirs_p-1:0]      reqs_s;
  logic [dirs_p-1:0]      valid_s;
  logic [dirs_p-1:0]      release_next_s;
  logic [dirs_p-1:0]      release_r;
  logic                   hdr_err_s;
  logic                   error_s;
  logic                   fire_s;
  logic                   load_s;
  logic                   dec_s;
  logic                   last_s;

  assign hdr_dir_s = fifo_data_i[hdr_dir_lsb_lp +: dir_width_p];
  assign hdr_len_s = fifo_data_i[len_lsb_lp +: len_width_p];
  assign fire_s    = fifo_v_i & yumi_i;

  // Payload bits above the header fields are not interpreted here.
  if (flit_width_p > hdr_top_lp) begin : g_payload
    logic unused_payload_s;
    assign unused_payload_s = ^fifo_data_i[flit_width_p-1:hdr_top_lp];
  end

  // Decode header direction and latched body direction into one-hot masks;
  // a direction beyond the last output is flagged as a routing error.
  always_comb begin
    hdr_onehot_s  = {dirs_p{1'b0}};
    body_onehot_s = {dirs_p{1'b0}};
    for (int i = 0; i < dirs_p; i++) begin
      hdr_onehot_s[i]  = (hdr_dir_s == dir_width_p'(i));
      body_onehot_s[i] = (dir_r == dir_width_p'(i));
    end
    hdr_err_s = (32'(hdr_dir_s) >= 32'(dirs_p));
  end

  // Sequencer next-state, request/valid steering and release generation.
  always_comb begin
    reqs_s         = {dirs_p{1'b0}};
    valid_s        = {dirs_p{1'b0}};
    release_next_s = {dirs_p{1'b0}};
    error_s        = 1'b0;
    load_s         = 1'b0;
    dec_s          = 1'b0;
    state_next_s   = state_r;
    if (reset_i) begin
      state_next_s = state_header_lp;
    end else begin
      case (state_r)
        state_header_lp: begin
          if (fifo_v_i && hdr_err_s) begin
            // Bad header is held at the FIFO head and never consumed.
            error_s = 1'b1;
          end else if (fifo_v_i) begin
            reqs_s  = hdr_onehot_s;
            valid_s = hdr_onehot_s;
            if (yumi_i) begin
              if (hdr_len_s == {len_width_p{1'b0}}) begin
                release_next_s = hdr_onehot_s;
              end else begin
                load_s       = 1'b1;
                state_next_s = state_body_lp;
              end
            end else begin
              state_next_s = state_header_lp;
            end
          end else begin
            state_next_s = state_header_lp;
          end
        end
        state_body_lp: begin
          if (fifo_v_i) begin
            valid_s = body_onehot_s;
          end else begin
            valid_s = {dirs_p{1'b0}};
          end
          if (fire_s) begin
            dec_s = 1'b1;
            if (last_s) begin
              state_next_s   = state_header_lp;
              release_next_s = body_onehot_s;
            end else begin
              state_next_s = state_body_lp;
            end
          end else begin
            state_next_s = state_body_lp;
          end
        end
        default: begin
          state_next_s = state_header_lp;
        end
      endcase
    end
  end

  // State, latched direction and the registered release pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r   <= state_header_lp;
      dir_r     <= {dir_width_p{1'b0}};
      release_r <= {dirs_p{1'b0}};
    end else begin
      state_r   <= state_next_s;
      release_r <= release_next_s;
      if (load_s) begin
        dir_r <= hdr_dir_s;
      end else begin
        dir_r <= dir_r;
      end
    end
  end

  bsg_wormhole_router_flit_counter
    #(.width_p(len_width_p))
    u_counter
    (.clk_i   (clk_i),
     .reset_i (reset_i),
     .load_i  (load_s),
     .count_i (hdr_len_s),
     .dec_i   (dec_s),
     .last_o  (last_s));

  assign reqs_o      = reqs_s;
  assign valid_o     = valid_s;
  assign error_o     = error_s;
  assign release_o   = release_r;
  assign fifo_yumi_o = yumi_i;

endmodule

// File: tb/tb_bsg_wormhole_router_input_sequencer.sv
// Directed bench for the wormhole input sequencer: a 2-direction instance
// for normal traffic and a 3-direction instance for out-of-range headers.
module tb_bsg_wormhole_router_input_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i;
  logic        fifo_v;
  logic [15:0] fifo_data;
  logic        yumi;
  logic [1:0]  reqs, valid, rel;
  logic        fifo_yumi, error;

  logic        fifo_v3;
  logic [15:0] fifo_data3;
  logic        yumi3;
  logic [2:0]  reqs3, valid3, rel3;
  logic        fifo_yumi3, error3;

  int tests_run = 0;
  int tests_failed = 0;

  bsg_wormhole_router_input_sequencer #(.dirs_p(2)) dut
    (.clk_i(clk), .reset_i(reset_i), .fifo_v_i(fifo_v), .fifo_data_i(fifo_data),
     .yumi_i(yumi), .reqs_o(reqs), .valid_o(valid), .release_o(rel),
     .fifo_yumi_o(fifo_yumi), .error_o(error));

  bsg_wormhole_router_input_sequencer #(.dirs_p(3)) dut3
    (.clk_i(clk), .reset_i(reset_i), .fifo_v_i(fifo_v3), .fifo_data_i(fifo_data3),
     .yumi_i(yumi3), .reqs_o(reqs3), .valid_o(valid3), .release_o(rel3),
     .fifo_yumi_o(fifo_yumi3), .error_o(error3));

  function automatic logic [15:0] hdr2(input logic [0:0] d, input logic [3:0] l);
    hdr2 = {11'd0, l, d};
  endfunction

  function automatic logic [15:0] hdr3(input logic [1:0] d, input logic [3:0] l);
    hdr3 = {10'd0, l, d};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic y);
    fifo_v = v; fifo_data = d; yumi = y;
    #2;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    fifo_v3 = 1'b1; fifo_data3 = hdr3(2'd3, 4'd0); yumi3 = 1'b0;
    drive(1'b1, hdr2(1'b1, 4'd0), 1'b1);
    cyc(); cyc(); #2;
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if ({reqs, valid, rel, error} !== 7'd0) begin
        tests_failed++;
        $display("FAIL reset_outs2: got reqs=%b valid=%b rel=%b err=%b want all 0", reqs, valid, rel, error);
      end
      tests_run++;
      if ({reqs3, valid3, rel3, error3} !== 10'd0) begin
        tests_failed++;
        $display("FAIL reset_outs3: got reqs=%b valid=%b rel=%b err=%b want all 0", reqs3, valid3, rel3, error3);
      end
      cyc(); #2;
    end
    reset_i = 1'b0; fifo_v3 = 1'b0;
    drive(1'b0, 16'd0, 1'b0);
    tests_run++;
    if (rel !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_no_release: got %b want 00", rel);
    end
    cyc();
  endtask

  task automatic test_single();
    drive(1'b1, hdr2(1'b1, 4'd0), 1'b1);
    tests_run++;
    if ({reqs, valid, rel, fifo_yumi} !== {2'b10, 2'b10, 2'b00, 1'b1}) begin
      tests_failed++;
      $display("FAIL single_hdr: got reqs=%b valid=%b rel=%b yumi=%b want 10 10 00 1", reqs, valid, rel, fifo_yumi);
    end
    cyc();
    drive(1'b0, 16'd0, 1'b0);
    tests_run++;
    if ({rel, reqs} !== {2'b10, 2'b00}) begin
      tests_failed++;
      $display("FAIL single_release: got rel=%b reqs=%b want 10 00", rel, reqs);
    end
    cyc();
    drive(1'b0, 16'd0, 1'b0);
    tests_run++;
    if (rel !== 2'b00) begin
      tests_failed++;
      $display("FAIL single_release_width: got %b want 00", rel);
    end
    cyc();
  endtask

  task automatic test_multi();
    drive(1'b1, hdr2(1'b0, 4'd3), 1'b1);
    tests_run++;
    if ({reqs, valid, rel} !== {2'b01, 2'b01, 2'b00}) begin
      tests_failed++;
      $display("FAIL multi_hdr: got reqs=%b valid=%b rel=%b want 01 01 00", reqs, valid, rel);
    end
    cyc();
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 16'hFFFF, 1'b1);
      tests_run++;
      if ({reqs, valid, rel} !== {2'b00, 2'b01, 2'b00}) begin
        tests_failed++;
        $display("FAIL multi_body%0d: got reqs=%b valid=%b rel=%b want 00 01 00", k, reqs, valid, rel);
      end
      cyc();
    end
    drive(1'b0, 16'd0, 1'b0);
    tests_run++;
    if ({rel, valid} !== {2'b01, 2'b00}) begin
      tests_failed++;
      $display("FAIL multi_release: got rel=%b valid=%b want 01 00", rel, valid);
    end
    cyc();
  endtask

  task automatic test_stall();
    drive(1'b1, hdr2(1'b1, 4'd2), 1'b1);
    cyc();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 16'd0, 1'b1);
      tests_run++;
      if ({reqs, valid, rel} !== 6'd0) begin
        tests_failed++;
        $display("FAIL stall_gap1_%0d: got reqs=%b valid=%b rel=%b want 00 00 00", k, reqs, valid, rel);
      end
      cyc();
    end
    drive(1'b1, 16'h0000, 1'b1);
    tests_run++;
    if ({reqs, valid, rel} !== {2'b00, 2'b10, 2'b00}) begin
      tests_failed++;
      $display("FAIL stall_body1: got reqs=%b valid=%b rel=%b want 00 10 00", reqs, valid, rel);
    end
    cyc();
    for (int k = 0; k < 5; k++) begin
      drive(k < 2 ? 1'b1 : 1'b0, 16'h0000, 1'b0);
      tests_run++;
      if ({valid, rel} !== {(k < 2) ? 2'b10 : 2'b00, 2'b00}) begin
        tests_failed++;
        $display("FAIL stall_gap2_%0d: got valid=%b rel=%b want %b 00", k, valid, rel, (k < 2) ? 2'b10 : 2'b00);
      end
      cyc();
    end
    drive(1'b1, 16'h0000, 1'b1);
    tests_run++;
    if ({valid, rel} !== {2'b10, 2'b00}) begin
      tests_failed++;
      $display("FAIL stall_body2: got valid=%b rel=%b want 10 00", valid, rel);
    end
    cyc();
    drive(1'b0, 16'd0, 1'b0);
    tests_run++;
    if (rel !== 2'b10) begin
      tests_failed++;
      $display("FAIL stall_release: got %b want 10", rel);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, hdr2(1'b0, 4'd1), 1'b1);
    cyc();
    drive(1'b1, 16'hFFFF, 1'b1);
    tests_run++;
    if ({reqs, valid} !== {2'b00, 2'b01}) begin
      tests_failed++;
      $display("FAIL b2b_body: got reqs=%b valid=%b want 00 01", reqs, valid);
    end
    cyc();
    drive(1'b1, hdr2(1'b1, 4'd0), 1'b1);
    tests_run++;
    if ({reqs, rel} !== {2'b10, 2'b01}) begin
      tests_failed++;
      $display("FAIL b2b_overlap: got reqs=%b rel=%b want 10 01", reqs, rel);
    end
    cyc();
    drive(1'b0, 16'd0, 1'b0);
    tests_run++;
    if (rel !== 2'b10) begin
      tests_failed++;
      $display("FAIL b2b_release2: got %b want 10", rel);
    end
    cyc();
  endtask

  task automatic test_max_len();
    drive(1'b1, hdr2(1'b0, 4'd15), 1'b1);
    cyc();
    for (int k = 1; k <= 15; k++) begin
      drive(1'b1, 16'hFFFF, 1'b1);
      tests_run++;
      if ({reqs, valid, rel} !== {2'b00, 2'b01, 2'b00}) begin
        tests_failed++;
        $display("FAIL maxlen_body%0d: got reqs=%b valid=%b rel=%b want 00 01 00", k, reqs, valid, rel);
      end
      cyc();
    end
    drive(1'b0, 16'd0, 1'b0);
    tests_run++;
    if (rel !== 2'b01) begin
      tests_failed++;
      $display("FAIL maxlen_release: got %b want 01", rel);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, hdr2(1'b1, 4'd3), 1'b1);
    cyc();
    drive(1'b1, 16'h0000, 1'b1);
    cyc();
    reset_i = 1'b1;
    drive(1'b1, 16'h0000, 1'b0);
    tests_run++;
    if ({reqs, valid, error} !== 5'd0) begin
      tests_failed++;
      $display("FAIL midreset_outs: got reqs=%b valid=%b err=%b want 00 00 0", reqs, valid, error);
    end
    cyc();
    reset_i = 1'b0;
    drive(1'b0, 16'd0, 1'b0);
    tests_run++;
    if (rel !== 2'b00) begin
      tests_failed++;
      $display("FAIL midreset_no_release: got %b want 00", rel);
    end
    cyc();
    drive(1'b1, hdr2(1'b0, 4'd0), 1'b1);
    tests_run++;
    if ({reqs, valid} !== {2'b01, 2'b01}) begin
      tests_failed++;
      $display("FAIL midreset_header: got reqs=%b valid=%b want 01 01", reqs, valid);
    end
    cyc();
    drive(1'b0, 16'd0, 1'b0);
    tests_run++;
    if (rel !== 2'b01) begin
      tests_failed++;
      $display("FAIL midreset_release: got %b want 01", rel);
    end
    cyc();
  endtask

  task automatic test_error();
    fifo_v3 = 1'b1; fifo_data3 = hdr3(2'd3, 4'd0); yumi3 = 1'b0;
    #2;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if ({error3, reqs3, valid3, fifo_yumi3, rel3} !== {1'b1, 3'b000, 3'b000, 1'b0, 3'b000}) begin
        tests_failed++;
        $display("FAIL error_hold%0d: got err=%b reqs=%b valid=%b yumi=%b rel=%b want 1 000 000 0 000",
                 k, error3, reqs3, valid3, fifo_yumi3, rel3);
      end
      cyc(); #2;
    end
    fifo_data3 = hdr3(2'd2, 4'd0); yumi3 = 1'b1;
    #1;
    tests_run++;
    if ({error3, reqs3, valid3} !== {1'b0, 3'b100, 3'b100}) begin
      tests_failed++;
      $display("FAIL error_dir2_hdr: got err=%b reqs=%b valid=%b want 0 100 100", error3, reqs3, valid3);
    end
    cyc();
    fifo_v3 = 1'b0; yumi3 = 1'b0;
    #2;
    tests_run++;
    if (rel3 !== 3'b100) begin
      tests_failed++;
      $display("FAIL error_dir2_release: got %b want 100", rel3);
    end
    cyc();
  endtask

  initial begin
    reset_i = 1'b1;
    fifo_v = 1'b0; fifo_data = 16'd0; yumi = 1'b0;
    fifo_v3 = 1'b0; fifo_data3 = 16'd0; yumi3 = 1'b0;
    cyc();
    test_reset();
    test_single();
    test_multi();
    test_stall();
    test_back_to_back();
    test_max_len();
    test_reset_mid();
    test_error();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bsg_wormhole_router_input_sequencer.md
BSG_WORMHOLE_ROUTER_INPUT_SEQUENCER -- requirements
Module: bsg_wormhole_router_input_sequencer

Interface
REQ-001 The block SHALL have parameter dirs_p, default 2: number of output directions (>=2).
REQ-002 The block SHALL have parameter flit_width_p, default 16: width of the flit presented at the input FIFO head.
REQ-003 The block SHALL have parameter len_width_p, default 4: width of the header length field (body flits following the header).
REQ-004 The block SHALL have parameter dir_width_p, default clog2(dirs_p): width of the header direction field.
REQ-005 The block SHALL have one clock and synchronous active-high reset, named clk_i and reset_i.
REQ-006 The block SHALL have port clk_i  input  1  clock.
REQ-007 The block SHALL have port reset_i  input  1  synchronous active-high reset.
REQ-008 The block SHALL have port fifo_v_i  input  1  flit valid at the input FIFO head.
REQ-009 The block SHALL have port fifo_data_i  input  flit_width_p  head flit; header dir = [dir_width_p-1:0]; len = [dir_width_p+len_width_p-1:dir_width_p].
REQ-010 The block SHALL have port yumi_i  input  1  head flit consumed this cycle (OR of this input's yumi from all output controls).
REQ-011 The block SHALL have port reqs_o  output  dirs_p  one-hot request to the output-control arbiters.
REQ-012 The block SHALL have port valid_o  output  dirs_p  flit valid steered to the routed direction.
REQ-013 The block SHALL have port release_o  output  dirs_p  one-cycle pulse freeing the output holding this packet.
REQ-014 The block SHALL have port fifo_yumi_o  output  1  pop to the input FIFO; equals yumi_i.
REQ-015 The block SHALL have port error_o  output  1  header direction >= dirs_p.

Function
REQ-016 The block SHALL implement two states: HEADER (expecting a header) and BODY (forwarding body flits).
REQ-017 In HEADER, the block SHALL drive reqs_o = valid_o = onehot(dir) & {dirs_p{fifo_v_i}}, combinationally from fifo_data_i.
REQ-018 In HEADER, on yumi_i with len==0, the block SHALL remain in HEADER and pulse release_o = onehot(dir) in the next cycle.
REQ-019 In HEADER, on yumi_i with len!=0, the block SHALL register dir_r=dir and count_r=len, and enter BODY.
REQ-020 In BODY, the block SHALL drive reqs_o = 0 and valid_o = onehot(dir_r) & {dirs_p{fifo_v_i}}.
REQ-021 In BODY, the block SHALL decrement count_r on each yumi_i.
REQ-022 In BODY, on yumi_i with count_r==1, the block SHALL return to HEADER and pulse release_o = onehot(dir_r) in the next cycle.
REQ-023 release_o SHALL be registered, high for exactly one cycle, and at most one-hot.
REQ-024 During a release pulse, the block SHALL be allowed to request concurrently with the next header (back-to-back packets, zero bubble).
REQ-025 The block SHALL ignore yumi_i while fifo_v_i==0, with no state change.
REQ-026 The block SHALL hold state and counter across stalls (fifo_v_i low or no yumi_i) indefinitely.
REQ-027 If the header dir >= dirs_p, the block SHALL drive reqs_o = valid_o = 0 and error_o = 1, hold the header unconsumed, and never advance.
REQ-028 A header with len = 2^len_width_p-1 SHALL forward exactly that many body flits (no counter wrap).

Reset
REQ-029 While reset_i is high, the block SHALL set state=HEADER, count_r=0, dir_r=0, and release_o=0.
REQ-030 Reset SHALL take effect mid-packet, discarding the partial packet with no release pulse.
REQ-031 While reset_i is high, reqs_o, valid_o, and error_o SHALL be 0 regardless of fifo_v_i.

Structure
REQ-032 The shared wormhole package SHALL hold the header field offsets and the HEADER/BODY state encoding.
REQ-033 The design SHALL use one sub-module, bsg_wormhole_router_flit_counter (load/decrement/last flag), instantiated once.
REQ-034 The block SHALL contain no arbitration; it pairs with one output-control instance per direction.

Verification
REQ-035 The bench SHALL drive dirs_p=2, header dir=1, len=0, yumi_i same cycle -> reqs_o=2'b10 that cycle, then release_o=2'b10 for one cycle.
REQ-036 The bench SHALL drive header dir=0, len=3, yumi_i every cycle -> valid_o=2'b01 for 4 cycles, reqs_o=2'b01 only in cycle 0, then release_o=2'b01 in cycle 4.
REQ-037 The bench SHALL drive len=2 with fifo_v_i low for 5 cycles between body flits -> count_r held, release occurs only after the second body yumi.
REQ-038 The bench SHALL drive two back-to-back packets (dir 0 len 1, then dir 1 len 0) -> release_o=2'b01 in the same cycle as reqs_o=2'b10.
REQ-039 The bench SHALL drive header dir=3 with dirs_p=3 -> error_o=1, reqs_o=0, fifo_yumi_o never asserted.
REQ-040 The bench SHALL assert reset_i in BODY with count_r=2 -> HEADER next cycle, no release_o, and the next flit is treated as a header.
